// File: rtl/exe_iter.sv
// exe_iter: execute stage with registered EX/MEM outputs and an iterative
// unsigned multiply / divide / remainder unit.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   exei_valid/ready    input handshake (accept = valid & ready)
//   exei_flush          synchronous abort of in-flight op and output
//   exei_instr/pc/...   operation, operands and sidebands from decode
//   exei_md_op          00 ALU op, 01 MUL, 10 DIVU, 11 REMU
//   exeo_valid          registered outputs carry a completed op
//   exeo_busy           iterative op in progress
//   exeo_*              registered result and sidebands to memory stage
module exe_iter #(
  parameter int WIDTH         = 16,
  parameter int REG_ADDR_W    = 4,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exei_valid,
  output logic                  exei_ready,
  input  logic                  exei_flush,
  input  logic [WIDTH-1:0]      exei_instr,
  input  logic [WIDTH-1:0]      exei_pc,
  input  logic [7:0]            exei_alu_opcode,
  input  logic [1:0]            exei_md_op,
  input  logic [WIDTH-1:0]      exei_op1,
  input  logic [WIDTH-1:0]      exei_op2,
  input  logic [REG_ADDR_W-1:0] exei_wreg_addr,
  input  logic [WIDTH-1:0]      exei_write_to_mem_data,
  input  logic [1:0]            exei_rwe,
  input  logic                  exei_branch,
  output logic                  exeo_valid,
  output logic                  exeo_busy,
  output logic [WIDTH-1:0]      exeo_instr,
  output logic [WIDTH-1:0]      exeo_pc,
  output logic [WIDTH-1:0]      exeo_result,
  output logic [WIDTH-1:0]      exeo_write_to_mem_data,
  output logic [REG_ADDR_W-1:0] exeo_wreg_addr,
  output logic [1:0]            exeo_rwe,
  output logic                  exeo_branch
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [7:0] ALU_OPCODE_NOP               = 8'h00;
  localparam logic [7:0] ALU_OPCODE_ADD               = 8'h01;
  localparam logic [7:0] ALU_OPCODE_SUB               = 8'h02;
  localparam logic [7:0] ALU_OPCODE_AND               = 8'h03;
  localparam logic [7:0] ALU_OPCODE_OR                = 8'h04;
  localparam logic [7:0] ALU_OPCODE_NOT               = 8'h05;
  localparam logic [7:0] ALU_OPCODE_CMP               = 8'h06;
  localparam logic [7:0] ALU_OPCODE_SHIFT_LEFT        = 8'h07;
  localparam logic [7:0] ALU_OPCODE_SHIFT_RIGHT_LOGIC = 8'h08;
  localparam logic [7:0] ALU_OPCODE_SHIFT_RIGHT_ARITH = 8'h09;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic                 accept, is_md, last_iter;
  logic [SH_W-1:0]      shamt;
  logic [WIDTH-1:0]     single_result;

  // iterative unit: a_q = multiplicand / shifting dividend (quotient),
  // b_q = multiplier / divisor, acc_q = product / partial remainder
  logic [1:0]           md_op_q;
  logic [WIDTH-1:0]     a_q, b_q, acc_q;
  logic [WIDTH-1:0]     a_nx, b_nx, acc_nx, md_result;
  logic [WIDTH:0]       shifted;
  logic [WIDTH-1:0]     diff;
  logic                 borrow;

  // sidebands captured at accept of an iterative op
  logic [WIDTH-1:0]     cap_instr, cap_pc, cap_wdata;
  logic [REG_ADDR_W-1:0] cap_wreg;
  logic [1:0]           cap_rwe, rwe_q;
  logic                 cap_branch, branch_q;

  assign exei_ready = (state == IDLE) && !exei_flush;
  assign accept     = exei_valid && exei_ready;
  assign is_md      = (ENABLE_MULDIV != 0) && (exei_md_op != 2'b00);
  assign last_iter  = (state == BUSY) && (cnt == CNT_W'(1));
  assign exeo_busy  = (state == BUSY);
  assign exeo_rwe    = exeo_valid ? rwe_q : '0;
  assign exeo_branch = exeo_valid & branch_q;
  assign shamt      = exei_op2[SH_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (exei_flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && is_md) state_next = BUSY;
        BUSY:    if (last_iter)       state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    single_result = WIDTH'(8'hFE);
    case (exei_alu_opcode)
      ALU_OPCODE_NOP:               single_result = '0;
      ALU_OPCODE_ADD:               single_result = exei_op1 + exei_op2;
      ALU_OPCODE_SUB:               single_result = exei_op1 - exei_op2;
      ALU_OPCODE_AND:               single_result = exei_op1 & exei_op2;
      ALU_OPCODE_OR:                single_result = exei_op1 | exei_op2;
      ALU_OPCODE_NOT:               single_result = ~exei_op1;
      ALU_OPCODE_CMP:               single_result = (exei_op1 == exei_op2) ? '0 : WIDTH'(1);
      ALU_OPCODE_SHIFT_LEFT:        single_result = exei_op1 << shamt;
      ALU_OPCODE_SHIFT_RIGHT_LOGIC: single_result = exei_op1 >> shamt;
      ALU_OPCODE_SHIFT_RIGHT_ARITH: single_result = $signed(exei_op1) >>> shamt;
      default:                      single_result = WIDTH'(8'hFE);
    endcase
    // only reached with md_op != 0 when the mul/div unit is absent
    if (exei_md_op != 2'b00) single_result = WIDTH'(8'hFE);
  end

  always_comb begin
    // restoring division step: shift in next dividend bit, subtract if it fits.
    // With divisor 0 every step fits, giving all-ones quotient and rem = op1.
    shifted = {acc_q, a_q[WIDTH-1]};
    borrow  = shifted < {1'b0, b_q};
    diff    = shifted[WIDTH-1:0] - b_q;
    a_nx    = a_q;
    b_nx    = b_q;
    acc_nx  = acc_q;
    if (md_op_q == 2'b01) begin
      acc_nx = acc_q + (b_q[0] ? a_q : '0);
      a_nx   = a_q << 1;
      b_nx   = b_q >> 1;
    end else begin
      acc_nx = borrow ? shifted[WIDTH-1:0] : diff;
      a_nx   = {a_q[WIDTH-2:0], ~borrow};
    end
    md_result = (md_op_q == 2'b10) ? a_nx : acc_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt                    <= '0;
      md_op_q                <= '0;
      a_q                    <= '0;
      b_q                    <= '0;
      acc_q                  <= '0;
      cap_instr              <= '0;
      cap_pc                 <= '0;
      cap_wdata              <= '0;
      cap_wreg               <= '0;
      cap_rwe                <= '0;
      cap_branch             <= 1'b0;
      exeo_valid             <= 1'b0;
      exeo_instr             <= '0;
      exeo_pc                <= '0;
      exeo_result            <= '0;
      exeo_write_to_mem_data <= '0;
      exeo_wreg_addr         <= '0;
      rwe_q                  <= '0;
      branch_q               <= 1'b0;
    end else if (exei_flush) begin
      cnt        <= '0;
      exeo_valid <= 1'b0;
    end else if (accept && is_md) begin
      cnt        <= CNT_W'(WIDTH);
      md_op_q    <= exei_md_op;
      a_q        <= exei_op1;
      b_q        <= exei_op2;
      acc_q      <= '0;
      cap_instr  <= exei_instr;
      cap_pc     <= exei_pc;
      cap_wdata  <= exei_write_to_mem_data;
      cap_wreg   <= exei_wreg_addr;
      cap_rwe    <= exei_rwe;
      cap_branch <= exei_branch;
      exeo_valid <= 1'b0;
    end else if (accept) begin
      exeo_valid             <= 1'b1;
      exeo_result            <= single_result;
      exeo_instr             <= exei_instr;
      exeo_pc                <= exei_pc;
      exeo_write_to_mem_data <= exei_write_to_mem_data;
      exeo_wreg_addr         <= exei_wreg_addr;
      rwe_q                  <= exei_rwe;
      branch_q               <= exei_branch;
    end else if (state == BUSY) begin
      cnt        <= cnt - CNT_W'(1);
      a_q        <= a_nx;
      b_q        <= b_nx;
      acc_q      <= acc_nx;
      exeo_valid <= last_iter;
      if (last_iter) begin
        exeo_result            <= md_result;
        exeo_instr             <= cap_instr;
        exeo_pc                <= cap_pc;
        exeo_write_to_mem_data <= cap_wdata;
        exeo_wreg_addr         <= cap_wreg;
        rwe_q                  <= cap_rwe;
        branch_q               <= cap_branch;
      end
    end else begin
      exeo_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_iter.sv
module tb_exe_iter;
  localparam int W = 16;
  localparam logic [7:0] OP_NOP = 8'h00, OP_ADD = 8'h01, OP_SUB = 8'h02, OP_AND = 8'h03,
                         OP_OR  = 8'h04, OP_NOT = 8'h05, OP_CMP = 8'h06, OP_SHL = 8'h07,
                         OP_SRL = 8'h08, OP_SRA = 8'h09;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 16-bit instance with mul/div
  logic        v, rdy, fl, br, ov, obusy, obr;
  logic [15:0] instr, pc, op1, op2, wdat, oinstr, opc_o, ores, owdat;
  logic [7:0]  opc;
  logic [1:0]  md, rwe, orwe;
  logic [3:0]  wra, owra;

  exe_iter #(.WIDTH(16), .REG_ADDR_W(4), .ENABLE_MULDIV(1)) dut16 (
    .clk(clk), .rst(rst), .exei_valid(v), .exei_ready(rdy), .exei_flush(fl),
    .exei_instr(instr), .exei_pc(pc), .exei_alu_opcode(opc), .exei_md_op(md),
    .exei_op1(op1), .exei_op2(op2), .exei_wreg_addr(wra), .exei_write_to_mem_data(wdat),
    .exei_rwe(rwe), .exei_branch(br), .exeo_valid(ov), .exeo_busy(obusy),
    .exeo_instr(oinstr), .exeo_pc(opc_o), .exeo_result(ores), .exeo_write_to_mem_data(owdat),
    .exeo_wreg_addr(owra), .exeo_rwe(orwe), .exeo_branch(obr));

  // 32-bit instance without mul/div
  logic        w_v, w_rdy, w_br, w_ov, w_busy, w_obr;
  logic [31:0] w_instr, w_pc, w_op1, w_op2, w_wdat, w_oinstr, w_opc, w_res, w_owdat;
  logic [7:0]  w_opcode;
  logic [1:0]  w_md, w_rwe, w_orwe;
  logic [3:0]  w_wra, w_owra;

  exe_iter #(.WIDTH(32), .REG_ADDR_W(4), .ENABLE_MULDIV(0)) dut32 (
    .clk(clk), .rst(rst), .exei_valid(w_v), .exei_ready(w_rdy), .exei_flush(1'b0),
    .exei_instr(w_instr), .exei_pc(w_pc), .exei_alu_opcode(w_opcode), .exei_md_op(w_md),
    .exei_op1(w_op1), .exei_op2(w_op2), .exei_wreg_addr(w_wra), .exei_write_to_mem_data(w_wdat),
    .exei_rwe(w_rwe), .exei_branch(w_br), .exeo_valid(w_ov), .exeo_busy(w_busy),
    .exeo_instr(w_oinstr), .exeo_pc(w_opc), .exeo_result(w_res), .exeo_write_to_mem_data(w_owdat),
    .exeo_wreg_addr(w_owra), .exeo_rwe(w_orwe), .exeo_branch(w_obr));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic on w-bit unsigned values.
  function automatic logic [31:0] ref_res(input int w, input bit muldiv, input logic [7:0] op,
                                          input logic [1:0] mdop, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned mask, x, y, r;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    x = {32'd0, a} & mask;
    y = {32'd0, b} & mask;
    sh = int'(y % longint'(w));
    r = 0;
    if (mdop != 2'b00) begin
      if (!muldiv) return 32'hFE;
      case (mdop)
        2'b01:   r = (x * y) & mask;
        2'b10:   r = (y == 0) ? mask : x / y;
        default: r = (y == 0) ? x : x % y;
      endcase
      return r[31:0];
    end
    case (op)
      OP_NOP: r = 0;
      OP_ADD: r = (x + y) & mask;
      OP_SUB: r = (x - y) & mask;
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_NOT: r = ~x & mask;
      OP_CMP: r = (x == y) ? 0 : 1;
      OP_SHL: r = (x << sh) & mask;
      OP_SRL: r = x >> sh;
      OP_SRA: begin
        r = x >> sh;
        if (x[w-1]) r = r | (mask & ~(mask >> sh));
      end
      default: r = 64'hFE;
    endcase
    return r[31:0];
  endfunction

  // Behavioural model of the 16-bit instance: an accepted iterative op
  // completes W edges after its accept edge unless flushed or reset.
  bit          m_pend, m_valid;
  int          m_done, edge_n;
  logic [15:0] p_res, p_instr, p_pc, p_wdat, m_res, m_instr, m_pc, m_wdat;
  logic [3:0]  p_wra, m_wra;
  logic [1:0]  p_rwe, m_rwe;
  logic        p_br, m_br;

  initial begin
    m_pend = 0; m_valid = 0; m_done = 0; edge_n = 0;
    m_res = '0; m_instr = '0; m_pc = '0; m_wdat = '0; m_wra = '0; m_rwe = '0; m_br = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pend = 0; m_valid = 0;
        m_res = '0; m_instr = '0; m_pc = '0; m_wdat = '0; m_wra = '0; m_rwe = '0; m_br = 1'b0;
      end else begin
        edge_n++;
        if (fl) begin
          m_pend = 0; m_valid = 0;
        end else if (m_pend) begin
          m_valid = (edge_n == m_done);
          if (m_valid) begin
            m_pend = 0;
            m_res = p_res; m_instr = p_instr; m_pc = p_pc; m_wdat = p_wdat;
            m_wra = p_wra; m_rwe = p_rwe; m_br = p_br;
          end
        end else if (v) begin
          if (md != 2'b00) begin
            m_pend = 1; m_done = edge_n + W; m_valid = 0;
            p_res = 16'(ref_res(W, 1, opc, md, {16'd0, op1}, {16'd0, op2}));
            p_instr = instr; p_pc = pc; p_wdat = wdat; p_wra = wra; p_rwe = rwe; p_br = br;
          end else begin
            m_valid = 1;
            m_res = 16'(ref_res(W, 1, opc, md, {16'd0, op1}, {16'd0, op2}));
            m_instr = instr; m_pc = pc; m_wdat = wdat; m_wra = wra; m_rwe = rwe; m_br = br;
          end
        end else begin
          m_valid = 0;
        end
      end
    end
  end

  // Compare process for the 16-bit instance.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("valid",  64'(ov),     64'(m_valid));
      check("ready",  64'(rdy),    64'(!m_pend && !fl));
      check("busy",   64'(obusy),  64'(m_pend));
      check("result", 64'(ores),   64'(m_res));
      check("instr",  64'(oinstr), 64'(m_instr));
      check("pc",     64'(opc_o),  64'(m_pc));
      check("wdata",  64'(owdat),  64'(m_wdat));
      check("wreg",   64'(owra),   64'(m_wra));
      check("rwe",    64'(orwe),   64'(m_valid ? m_rwe : 2'b00));
      check("branch", 64'(obr),    64'(m_valid & m_br));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set16(input bit vv, input logic [7:0] o, input logic [1:0] m,
                       input logic [15:0] a, input logic [15:0] b);
    v = vv; opc = o; md = m; op1 = a; op2 = b;
    instr = 16'($urandom); pc = 16'($urandom); wdat = 16'($urandom);
    wra = 4'($urandom); rwe = 2'($urandom); br = 1'($urandom);
  endtask

  task automatic run_op(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input string name);
    bit seen;
    seen = 0;
    set16(1, OP_NOP, m, a, b);
    cyc();
    v = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ov) seen = 1;
    end
    check({name, "_done"}, 64'(seen), 64'(1));
    if (seen) check(name, 64'(ores), 64'(exp));
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  m;
    logic [15:0] s_pc;
    logic [3:0]  s_wra;
    fl = 0;
    set16(0, OP_NOP, 2'b00, 16'h0, 16'h0);
    w_v = 0; w_opcode = '0; w_md = '0; w_op1 = '0; w_op2 = '0; w_instr = '0; w_pc = '0;
    w_wdat = '0; w_wra = '0; w_rwe = '0; w_br = 1'b0;
    repeat (3) cyc();
    rst = 0;
    cyc();

    // reset in the middle of an iterative op
    set16(1, OP_ADD, 2'b01, 16'h1234, 16'h0056);
    cyc();
    v = 0;
    cyc(); cyc();
    rst = 1;
    #1;
    check("rst_busy",   64'(obusy), 64'(0));
    check("rst_valid",  64'(ov),    64'(0));
    check("rst_result", 64'(ores),  64'(0));
    check("rst_ready",  64'(rdy),   64'(1));
    cyc();
    rst = 0;
    cyc();

    // ADD wrap-around, sidebands pass through
    set16(1, OP_ADD, 2'b00, 16'hFFFF, 16'h0002);
    s_pc = pc; s_wra = wra;
    cyc();
    v = 0;
    @(negedge clk);
    check("add_valid",  64'(ov),   64'(1));
    check("add_result", 64'(ores), 64'(16'h0001));
    check("add_pc",     64'(opc_o), 64'(s_pc));
    check("add_wreg",   64'(owra), 64'(s_wra));
    cyc();

    // shifts, back to back
    set16(1, OP_SRA, 2'b00, 16'h8000, 16'h0013);
    cyc();
    set16(1, OP_SRL, 2'b00, 16'h8000, 16'h0013);
    @(negedge clk);
    check("sra_result", 64'(ores), 64'(16'hF000));
    cyc();
    v = 0;
    @(negedge clk);
    check("srl_result", 64'(ores), 64'(16'h1000));
    check("srl_valid",  64'(ov),   64'(1));
    cyc();

    // MUL with valid held, next op waits then is accepted on completion
    set16(1, OP_NOP, 2'b01, 16'h0123, 16'h0010);
    @(negedge clk);
    check("mul_ready_pre", 64'(rdy), 64'(1));
    cyc();
    set16(1, OP_ADD, 2'b00, 16'h0001, 16'h0001);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("mul_ready_low", 64'(rdy),   64'(0));
      check("mul_busy",      64'(obusy), 64'(1));
    end
    @(negedge clk);
    check("mul_valid",  64'(ov),   64'(1));
    check("mul_result", 64'(ores), 64'(16'h1230));
    check("mul_ready",  64'(rdy),  64'(1));
    cyc();
    v = 0;
    @(negedge clk);
    check("held_valid",  64'(ov),   64'(1));
    check("held_result", 64'(ores), 64'(16'h0002));
    cyc();

    run_op(2'b10, 16'd100,  16'd7, 16'd14,    "divu");
    run_op(2'b11, 16'd100,  16'd7, 16'd2,     "remu");
    run_op(2'b10, 16'd1234, 16'd0, 16'hFFFF,  "divu_zero");
    run_op(2'b11, 16'd55,   16'd0, 16'd55,    "remu_zero");
    run_op(2'b01, 16'hFFFF, 16'hFFFF, 16'h0001, "mul_wrap");

    // flush at busy cycle 8 of a DIVU with valid held
    set16(1, OP_NOP, 2'b10, 16'd1000, 16'd3);
    cyc();
    set16(1, OP_ADD, 2'b00, 16'd5, 16'd6);
    repeat (7) cyc();
    fl = 1;
    @(negedge clk);
    check("flush_ready", 64'(rdy), 64'(0));
    cyc();
    fl = 0; v = 0;
    @(negedge clk);
    check("flush_ready_after", 64'(rdy),   64'(1));
    check("flush_busy_after",  64'(obusy), 64'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("flush_no_valid", 64'(ov), 64'(0));
    end
    cyc();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      m = ($urandom % 2 == 0) ? 2'b00 : 2'($urandom);
      set16(($urandom % 3) != 0, 8'($urandom % 11), m, 16'($urandom),
            ($urandom % 8 == 0) ? 16'h0 : 16'($urandom));
      fl = ($urandom % 30) == 0;
      cyc();
    end
    v = 0; fl = 0;
    repeat (20) cyc();

    // 32-bit instance without mul/div: always single cycle
    for (int i = 0; i < 40; i++) begin
      w_opcode = 8'($urandom % 11);
      w_md = (i % 4 == 0) ? 2'b01 : 2'($urandom);
      w_op1 = $urandom; w_op2 = $urandom; w_instr = $urandom; w_v = 1;
      @(negedge clk);
      check("w_ready", 64'(w_rdy), 64'(1));
      @(posedge clk);
      #1;
      check("w_valid",  64'(w_ov),     64'(1));
      check("w_busy",   64'(w_busy),   64'(0));
      check("w_result", 64'(w_res),    64'(ref_res(32, 0, w_opcode, w_md, w_op1, w_op2)));
      check("w_instr",  64'(w_oinstr), 64'(w_instr));
      #1;
    end
    w_opcode = OP_ADD; w_md = 2'b01; w_op1 = 32'd3; w_op2 = 32'd4;
    @(posedge clk);
    #1;
    check("w_md_fe", 64'(w_res), 64'(32'h000000FE));
    #1;
    w_md = 2'b00; w_op1 = 32'd5; w_op2 = 32'd7; w_instr = 32'hDEADBEEF; w_rwe = 2'b11;
    @(posedge clk);
    #1;
    check("w_pre_rst", 64'(w_res), 64'(32'd12));
    #1;
    rst = 1;
    #1;
    check("w_rst_valid",  64'(w_ov),     64'(0));
    check("w_rst_result", 64'(w_res),    64'(0));
    check("w_rst_instr",  64'(w_oinstr), 64'(0));
    check("w_rst_rwe",    64'(w_orwe),   64'(0));
    check("w_rst_busy",   64'(w_busy),   64'(0));
    w_v = 0;
    cyc();
    rst = 0;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exe_iter.md
Name: exe_iter

Overview:
- Parametrised successor to the single-cycle execute stage: same ALU operation set, generalised to WIDTH bits.
- Adds an iterative unsigned multiply/divide/remainder unit.
- Registers its outputs, so the EX/MEM pipeline register lives inside the block.
- Sits between decode and memory stages; uses a valid/ready handshake to stall decode during multi-cycle ops.

Parameters:
WIDTH, 16, datapath width (op1, op2, result, pc, instr, mem data); power of two, at least 8
REG_ADDR_W, 4, width of write-back register address
ENABLE_MULDIV, 1, 0 removes the mul/div unit; md_op != 0 then yields result 'hFE in one cycle

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
exei_valid  in  1  input operation present
exei_ready  out  1  block can accept; accept = exei_valid & exei_ready
exei_flush  in  1  synchronous abort of in-flight op and output
exei_instr  in  WIDTH  instruction, passed through
exei_pc  in  WIDTH  pc, passed through
exei_alu_opcode  in  8  existing ALU_OPCODE_* encoding
exei_md_op  in  2  00 use alu_opcode, 01 MUL (low WIDTH bits), 10 DIVU, 11 REMU
exei_op1  in  WIDTH  operand 1 / dividend / multiplicand
exei_op2  in  WIDTH  operand 2 / divisor / multiplier / shift amount
exei_wreg_addr  in  REG_ADDR_W  write-back register
exei_write_to_mem_data  in  WIDTH  store data, passed through
exei_rwe  in  2  read/write enables, passed through
exei_branch  in  1  branch flag, passed through
exeo_valid  out  1  registered outputs carry a completed op this cycle
exeo_busy  out  1  iterative op in progress
exeo_instr, exeo_pc, exeo_result, exeo_write_to_mem_data  out  WIDTH  registered
exeo_wreg_addr  out  REG_ADDR_W  registered
exeo_rwe  out  2  registered; forced 00 when exeo_valid=0
exeo_branch  out  1  registered; forced 0 when exeo_valid=0

Behaviour:
- Reset (async):
  - state IDLE, counter 0, all exeo_* 0, exeo_valid 0, exeo_busy 0.
  - exei_ready is 1 once rst is deasserted.
- States: IDLE and BUSY. exei_ready = (state==IDLE) & ~exei_flush.
- Single-cycle op (md_op==00, or ENABLE_MULDIV=0):
  - On the accept edge, result and all sidebands are registered.
  - exeo_valid=1 for the following cycle.
  - Back-to-back accepts give one result per cycle.
- ALU results, WIDTH-bit, wrap-around:
  - NOP: 0. ADD/SUB: modulo 2^WIDTH. AND/OR.
  - NOT: ~op1.
  - CMP: 0 if equal, else 1.
  - SHIFT_LEFT / SHIFT_RIGHT_LOGIC / SHIFT_RIGHT_ARITH: shift by op2[log2(WIDTH)-1:0]; upper op2 bits ignored. Arithmetic shift replicates op1 MSB.
  - Unknown opcode: 'hFE zero-extended.
- Multi-cycle op (md_op!=00, ENABLE_MULDIV=1):
  - On the accept edge, capture operands and sidebands, load counter=WIDTH, enter BUSY. exeo_valid=0 in the next cycle.
  - BUSY: one iteration per edge (shift-add multiply; restoring divide, 1 quotient bit per edge). Counter decrements each edge.
  - On the edge where counter goes 1->0: write result, return to IDLE, exeo_valid=1 next cycle.
  - Accept-to-valid latency is WIDTH+1 edges. exei_ready returns high in the same cycle exeo_valid rises.
  - exeo_busy = (state==BUSY).
- Arithmetic:
  - MUL: low WIDTH bits of unsigned product.
  - DIVU with op2=0: quotient all-ones.
  - REMU with op2=0: remainder = op1.
- No accept in a cycle: exeo_valid=0 next cycle. Data outputs hold their last values; rwe/branch read as 0 (bubble).
- exei_flush=1:
  - Next edge: state IDLE, counter 0, exeo_valid 0.
  - Any input presented that cycle is not accepted.
  - Flush dominates completion on the same edge; the result is discarded.
- rst asserted mid-BUSY: immediate abort to reset values. No partial result is ever emitted.
- Operand inputs are ignored while BUSY; the captured copies are used.

Test Plan:
- Reset mid-run, then ADD op1=16'hFFFF op2=16'h0002 valid one cycle -> next cycle exeo_valid=1, exeo_result=16'h0001, sidebands match inputs.
- SHIFT_RIGHT_ARITH op1=16'h8000 op2=16'h0013 (amount 3) -> result 16'hF000. SHIFT_RIGHT_LOGIC with the same operands -> 16'h1000.
- MUL op1=16'h0123 op2=16'h0010 with exei_valid held high -> exei_ready=0 and exeo_busy=1 for 16 cycles; exeo_valid=1 at edge 17 with result 16'h1230; the next held op is accepted that cycle.
- DIVU 16'd100/16'd7 -> 16'd14; REMU -> 16'd2; DIVU x/0 -> 16'hFFFF; REMU 16'd55/0 -> 16'd55.
- Flush asserted at BUSY cycle 8 of a DIVU with exei_valid=1 -> no exeo_valid for that op; input not accepted on the flush cycle; exei_ready=1 in the cycle after.
- WIDTH=32, ENABLE_MULDIV=0: md_op=01 -> result 32'h000000FE after 1 cycle, exeo_busy never asserts; rst pulsed mid-stream -> all outputs 0 asynchronously.
